// File: rtl/dmem_lsu.sv
// Load/store unit driving a synchronous-read, byte-write-enable data memory port.
// Optional define MISALIGN_TRAP_EN turns misaligned halfword/word accesses into error responses.
module dmem_lsu #(
  parameter int AWIDTH = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [AWIDTH-1:0] dmem_addra,
  output logic [31:0]       dmem_dina,
  output logic [3:0]        dmem_wea,
  input  logic [31:0]       dmem_douta
);

  typedef enum logic [1:0] {IDLE, RD, RSP} state_t;

  state_t      state, state_next;
  logic [1:0]  off;
  logic [2:0]  f3;
  logic [31:0] rdata;
  logic        err;

  logic        fire;
  logic        store_legal;
  logic        load_legal;
  logic        misalign;
  logic        req_err;
  logic [3:0]  wea_enc;
  logic [31:0] load_data;
  logic [31:0] shifted;

  // Upper byte-address bits wrap and are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[31:AWIDTH+2];

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RSP);
  assign rsp_rdata = rdata;
  assign rsp_err   = err;
  assign fire      = req_valid & req_ready;

  assign store_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
  assign load_legal  = store_legal || (req_funct3 == 3'b100) || (req_funct3 == 3'b101);

`ifdef MISALIGN_TRAP_EN
  assign misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                    ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign req_err = (req_we ? !store_legal : !load_legal) | misalign;

  assign dmem_addra = req_addr[AWIDTH+1:2];

  always_comb begin
    dmem_dina = req_wdata;
    wea_enc   = 4'b1111;
    unique case (req_funct3[1:0])
      2'b00: begin
        dmem_dina = {4{req_wdata[7:0]}};
        wea_enc   = 4'b0001 << req_addr[1:0];
      end
      2'b01: begin
        dmem_dina = {2{req_wdata[15:0]}};
        wea_enc   = req_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        dmem_dina = req_wdata;
        wea_enc   = 4'b1111;
      end
    endcase
  end

  // Gated by rst_n directly so no write can escape while reset is asserted.
  assign dmem_wea = (rst_n && fire && req_we && !req_err) ? wea_enc : 4'b0000;

  assign shifted = dmem_douta >> {off, 3'b000};

  always_comb begin
    load_data = dmem_douta;
    unique case (f3[1:0])
      2'b00:   load_data = {{24{shifted[7] & ~f3[2]}}, shifted[7:0]};
      2'b01:   load_data = off[1] ? {{16{dmem_douta[31] & ~f3[2]}}, dmem_douta[31:16]}
                                  : {{16{dmem_douta[15] & ~f3[2]}}, dmem_douta[15:0]};
      default: load_data = dmem_douta;
    endcase
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (fire) state_next = (!req_we && !req_err) ? RD : RSP;
      RD:   state_next = RSP;
      RSP:  if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      off   <= 2'b00;
      f3    <= 3'b000;
      rdata <= 32'h0;
      err   <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && fire) begin
        off <= req_addr[1:0];
        f3  <= req_funct3;
        if (req_we || req_err) begin
          rdata <= 32'h0;
          err   <= req_err;
        end
      end else if (state == RD) begin
        rdata <= load_data;
        err   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with a small synchronous-read byte-write RAM attached.
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [13:0] dmem_addra;
  logic [31:0] dmem_dina;
  logic [3:0]  dmem_wea;
  logic [31:0] dmem_douta;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:15];

  always #5 clk = ~clk;

  dmem_lsu #(.AWIDTH(14)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .dmem_addra (dmem_addra),
    .dmem_dina  (dmem_dina),
    .dmem_wea   (dmem_wea),
    .dmem_douta (dmem_douta)
  );

  // Environment RAM: registered read, read-before-write, byte lanes.
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (dmem_wea[b]) mem[dmem_addra[3:0]][8*b +: 8] <= dmem_dina[8*b +: 8];
    dmem_douta <= mem[dmem_addra[3:0]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
    $display("check %-16s observed=%08h expected=%08h", tag, obs, exp);
  endtask

  task automatic issue(input string tag, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] exp_wea, input logic [31:0] exp_dina);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    #1;
    check({tag, "_ready"}, {31'b0, req_ready}, 32'h1);
    check({tag, "_wea"}, {28'b0, dmem_wea}, {28'b0, exp_wea});
    check({tag, "_addra"}, {18'b0, dmem_addra}, {18'b0, addr[15:2]});
    if (we) check({tag, "_dina"}, dmem_dina, exp_dina);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic response(input string tag, input int lat, input logic [31:0] exp_rdata,
                          input logic exp_err);
    if (lat == 2) begin
      check({tag, "_early"}, {31'b0, rsp_valid}, 32'h0);
      check({tag, "_rdwea"}, {28'b0, dmem_wea}, 32'h0);
      @(posedge clk);
      #1;
    end
    check({tag, "_valid"}, {31'b0, rsp_valid}, 32'h1);
    check({tag, "_rdata"}, rsp_rdata, exp_rdata);
    check({tag, "_err"}, {31'b0, rsp_err}, {31'b0, exp_err});
    check({tag, "_busy"}, {31'b0, req_ready}, 32'h0);
    @(posedge clk);
    #1;
    check({tag, "_drain"}, {31'b0, rsp_valid}, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;

    // Reset with a store pending: nothing may be written.
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h0; req_wdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    check("rst_wea", {28'b0, dmem_wea}, 32'h0);
    check("rst_valid", {31'b0, rsp_valid}, 32'h0);
    check("rst_rdata", rsp_rdata, 32'h0);
    check("rst_err", {31'b0, rsp_err}, 32'h0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;

    issue("sw4", 1'b1, 3'b010, 32'h4, 32'h123480CD, 4'b1111, 32'h123480CD);
    response("sw4_rsp", 1, 32'h0, 1'b0);
    issue("lw4", 1'b0, 3'b010, 32'h4, 32'h0, 4'b0000, 32'h0);
    response("lw4_rsp", 2, 32'h123480CD, 1'b0);
    issue("lb5", 1'b0, 3'b000, 32'h5, 32'h0, 4'b0000, 32'h0);
    response("lb5_rsp", 2, 32'hFFFFFF80, 1'b0);
    issue("lbu5", 1'b0, 3'b100, 32'h5, 32'h0, 4'b0000, 32'h0);
    response("lbu5_rsp", 2, 32'h00000080, 1'b0);
    issue("lh6", 1'b0, 3'b001, 32'h6, 32'h0, 4'b0000, 32'h0);
    response("lh6_rsp", 2, 32'h00001234, 1'b0);
    issue("lhu4", 1'b0, 3'b101, 32'h4, 32'h0, 4'b0000, 32'h0);
    response("lhu4_rsp", 2, 32'h000080CD, 1'b0);

    issue("sb5", 1'b1, 3'b000, 32'h5, 32'h000000AB, 4'b0010, 32'hABABABAB);
    response("sb5_rsp", 1, 32'h0, 1'b0);
    issue("lw4b", 1'b0, 3'b010, 32'h4, 32'h0, 4'b0000, 32'h0);
    response("lw4b_rsp", 2, 32'h1234ABCD, 1'b0);

    issue("lw6", 1'b0, 3'b010, 32'h6, 32'h0, 4'b0000, 32'h0);
`ifdef MISALIGN_TRAP_EN
    response("lw6_rsp", 1, 32'h0, 1'b1);
`else
    response("lw6_rsp", 2, 32'h1234ABCD, 1'b0);
`endif

    issue("sha", 1'b1, 3'b001, 32'hA, 32'h0000BEEF, 4'b1100, 32'hBEEFBEEF);
    response("sha_rsp", 1, 32'h0, 1'b0);
    issue("lha", 1'b0, 3'b001, 32'hA, 32'h0, 4'b0000, 32'h0);
    response("lha_rsp", 2, 32'hFFFFBEEF, 1'b0);
    issue("lhua", 1'b0, 3'b101, 32'hA, 32'h0, 4'b0000, 32'h0);
    response("lhua_rsp", 2, 32'h0000BEEF, 1'b0);

    issue("lwwrap", 1'b0, 3'b010, 32'h00010004, 32'h0, 4'b0000, 32'h0);
    response("lwwrap_rsp", 2, 32'h1234ABCD, 1'b0);

    issue("sbad", 1'b1, 3'b011, 32'h8, 32'hFFFFFFFF, 4'b0000, 32'hFFFFFFFF);
    response("sbad_rsp", 1, 32'h0, 1'b1);
    issue("lbad", 1'b0, 3'b110, 32'h8, 32'h0, 4'b0000, 32'h0);
    response("lbad_rsp", 1, 32'h0, 1'b1);

    // Back-pressure: response must hold and no new request may be taken.
    rsp_ready = 1'b0;
    issue("lwst", 1'b0, 3'b010, 32'h4, 32'h0, 4'b0000, 32'h0);
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h4; req_wdata = 32'h55555555;
    for (int i = 0; i < 3; i++) begin
      check("stall_valid", {31'b0, rsp_valid}, 32'h1);
      check("stall_rdata", rsp_rdata, 32'h1234ABCD);
      check("stall_ready", {31'b0, req_ready}, 32'h0);
      check("stall_wea", {28'b0, dmem_wea}, 32'h0);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("stall_drain", {31'b0, rsp_valid}, 32'h0);
    check("stall_idle", {31'b0, req_ready}, 32'h1);

    // Reset while a load is in flight.
    issue("lwrst", 1'b0, 3'b010, 32'h4, 32'h0, 4'b0000, 32'h0);
    #2;
    rst_n = 1'b0;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h0; req_wdata = 32'hDEADBEEF;
    #1;
    check("rd_rst_valid", {31'b0, rsp_valid}, 32'h0);
    check("rd_rst_ready", {31'b0, req_ready}, 32'h1);
    check("rd_rst_wea", {28'b0, dmem_wea}, 32'h0);
    @(posedge clk); #1;
    check("rd_rst_hold", {31'b0, rsp_valid}, 32'h0);
    req_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_valid", {31'b0, rsp_valid}, 32'h0);
    check("post_rst_ready", {31'b0, req_ready}, 32'h1);
    issue("lw0", 1'b0, 3'b010, 32'h0, 32'h0, 4'b0000, 32'h0);
    response("lw0_rsp", 2, 32'h0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
